// File: rtl/axis_mux_sched.sv
// Packet-level weighted round-robin scheduler for a 4:1 AXI4-Stream mux.
// Drives registered enable/select, grants whole frames, flags stalled frames.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   s_axis_tvalid   : per-port valid (requests)
//   s_axis_tready   : per-port ready tapped from the mux
//   s_axis_tlast    : per-port last
//   port_enable     : per-port arbitration mask
//   weight          : packed per-port packets-per-turn (0 acts as 1)
//   enable, select  : registered mux controls
//   busy            : high in GRANT or ACTIVE
//   stall_timeout   : one-cycle watchdog pulse
module axis_mux_sched #(
  parameter int S_COUNT        = 4,
  parameter int WEIGHT_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [S_COUNT-1:0]              s_axis_tvalid,
  input  logic [S_COUNT-1:0]              s_axis_tready,
  input  logic [S_COUNT-1:0]              s_axis_tlast,
  input  logic [S_COUNT-1:0]              port_enable,
  input  logic [S_COUNT*WEIGHT_WIDTH-1:0] weight,
  output logic                            enable,
  output logic [$clog2(S_COUNT)-1:0]      select,
  output logic                            busy,
  output logic                            stall_timeout
);

  localparam int SW = $clog2(S_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic                    enable_nx;
  logic [SW-1:0]           last_port;
  logic [WEIGHT_WIDTH-1:0] credit;

  logic [S_COUNT-1:0]      req;
  logic                    hs;
  logic                    eof;
  logic                    grant_go;
  logic                    keep_turn;
  logic [SW-1:0]           winner;
  logic [WEIGHT_WIDTH-1:0] wsel;
  logic [WEIGHT_WIDTH-1:0] wload;

  assign req  = s_axis_tvalid & port_enable;
  assign hs   = s_axis_tvalid[select] & s_axis_tready[select];
  assign eof  = hs & s_axis_tlast[select];

  assign grant_go  = (state == IDLE) && (|req);
  assign keep_turn = req[last_port] && (credit != '0);

  // Rotating search starting after last_port; last_port is the
  // final candidate so a lone requester keeps winning.
  always_comb begin
    logic found;
    winner = last_port;
    found  = keep_turn;
    for (int k = 1; k <= S_COUNT; k++) begin
      int idx;
      idx = (int'(last_port) + k) % S_COUNT;
      if (!found && req[idx]) begin
        winner = SW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign wsel  = weight[int'(winner)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign wload = (wsel == '0) ? '0 : wsel - WEIGHT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      enable    <= 1'b0;
      select    <= '0;
      last_port <= SW'(S_COUNT - 1);
      credit    <= '0;
    end else begin
      state  <= state_nx;
      enable <= enable_nx;
      if (grant_go) begin
        select    <= winner;
        last_port <= winner;
        credit    <= keep_turn ? credit - WEIGHT_WIDTH'(1) : wload;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (|req) state_nx = GRANT;
      end
      GRANT: begin
        if (eof)     state_nx = IDLE;
        else if (hs) state_nx = ACTIVE;
      end
      ACTIVE: begin
        if (eof) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // enable is high only while the mux still has to latch select
  always_comb begin
    enable_nx = (state_nx == GRANT);
    busy      = (state != IDLE);
  end

  if (TIMEOUT_CYCLES > 0) begin : g_wd
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
    logic [CW-1:0] stall_cnt;

    // Saturates at TMAX so the pulse fires once per stall.
    always_ff @(posedge clk) begin
      if (rst || !busy || hs) begin
        stall_cnt     <= '0;
        stall_timeout <= 1'b0;
      end else begin
        if (stall_cnt != TMAX) stall_cnt <= stall_cnt + CW'(1);
        stall_timeout <= (stall_cnt == TMAX - CW'(1));
      end
    end
  end else begin : g_nowd
    assign stall_timeout = 1'b0;
  end

endmodule

// File: tb/tb_axis_mux_sched.sv
// Directed bench for axis_mux_sched with a small mux and source model.
// Grants are logged at busy rise and compared to hand-derived orders.
module tb_axis_mux_sched;

  localparam int N  = 4;
  localparam int WW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    tvalid;
  logic [N-1:0]    tready;
  logic [N-1:0]    tlast;
  logic [N-1:0]    pen;
  logic [N*WW-1:0] wgt;
  logic            enable;
  logic [1:0]      select;
  logic            busy;
  logic            stall;

  axis_mux_sched #(
    .S_COUNT(N),
    .WEIGHT_WIDTH(WW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .s_axis_tlast(tlast),
    .port_enable(pen),
    .weight(wgt),
    .enable(enable),
    .select(select),
    .busy(busy),
    .stall_timeout(stall)
  );

  logic [N-1:0] src_on = '0;
  int           src_len [N];
  int           pos [N];
  logic         sink_ready = 1'b1;
  logic         mframe;
  logic [1:0]   msel;
  logic         mhs;
  logic         meof;

  always_comb begin
    tvalid = src_on;
    for (int i = 0; i < N; i++) begin
      tlast[i]  = (pos[i] == src_len[i] - 1);
      tready[i] = mframe && (int'(msel) == i) && sink_ready;
    end
  end

  assign mhs  = mframe && tvalid[msel] && sink_ready;
  assign meof = mhs && tlast[msel];

  always_ff @(posedge clk) begin
    if (rst) begin
      mframe <= 1'b0;
      msel   <= '0;
      for (int i = 0; i < N; i++) pos[i] <= 0;
    end else begin
      if (mframe) begin
        if (meof) mframe <= 1'b0;
      end else if (enable) begin
        mframe <= 1'b1;
        msel   <= select;
      end
      if (mhs) pos[msel] <= tlast[msel] ? 0 : pos[msel] + 1;
    end
  end

  int cyc = 0;
  int latch_cnt = 0;
  int beats [N];
  int frames [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      beats[i]   = 0;
      frames[i]  = 0;
      src_len[i] = 1;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (!mframe && enable) latch_cnt = latch_cnt + 1;
      if (mhs) begin
        beats[msel] = beats[msel] + 1;
        if (tlast[msel]) frames[msel] = frames[msel] + 1;
      end
    end
  end

  int   glog [256];
  int   gstamp [256];
  int   gcount = 0;
  int   viol = 0;
  int   stall_cnt = 0;
  logic busy_q = 1'b0;
  logic hs_q = 1'b0;
  logic [1:0] sel_q = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy && !busy_q && gcount < 256) begin
        glog[gcount]   = int'(select);
        gstamp[gcount] = cyc;
        gcount = gcount + 1;
      end
      if (busy && busy_q && select != sel_q) viol = viol + 1;
      if (hs_q && enable) viol = viol + 1;
      if (enable && !busy) viol = viol + 1;
      if (stall) stall_cnt = stall_cnt + 1;
    end
    busy_q = busy;
    sel_q  = select;
    hs_q   = mhs;
  end

  int errors = 0;
  int checks = 0;
  int gbase  = 0;
  int vbase  = 0;
  int lbase  = 0;
  int fbase [N];
  int bbase [N];

  int exp_rr [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_w  [21] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1,
                      2, 2, 3, 0, 1, 2, 2, 3, 0, 1};
  int exp_sb [4]  = '{1, 3, 1, 3};
  int exp_mk [6]  = '{0, 1, 0, 0, 0, 1};

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic start_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic end_reset();
    gbase = gcount;
    vbase = viol;
    lbase = latch_cnt;
    for (int i = 0; i < N; i++) begin
      fbase[i] = frames[i];
      bbase[i] = beats[i];
    end
    rst = 1'b0;
  endtask

  task automatic wait_grants(input string tag, input int n);
    int k;
    k = 0;
    while ((gcount - gbase) < n && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, int'((gcount - gbase) >= n), 1);
  endtask

  task automatic set_len(input int len);
    for (int i = 0; i < N; i++) src_len[i] = len;
  endtask

  initial begin
    #5000000;
    $fatal(1, "FAIL global_timeout");
  end

  initial begin
    int found;
    int pulses;
    int pulse_n;

    pen = '1;
    wgt = 16'h1111;
    set_len(3);
    src_on = 4'b0100;
    start_reset();
    #1;
    chk("rst_enable", int'(enable), 0);
    chk("rst_select", int'(select), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stall", int'(stall), 0);

    // single port, 3-beat frames
    end_reset();
    @(negedge clk);
    #1;
    chk("lat_enable", int'(enable), 1);
    chk("lat_select", int'(select), 2);
    wait_grants("p1_wait", 5);
    for (int i = 0; i < 5; i++) chk("p1_sel", glog[gbase+i], 2);
    chk("p1_period", gstamp[gbase+1] - gstamp[gbase], 5);
    chk("p1_frames", frames[2] - fbase[2], 4);
    chk("p1_beats", beats[2] - bbase[2], 12);
    chk("p1_latch", latch_cnt - lbase, 4);
    chk("p1_viol", viol - vbase, 0);

    // plain round-robin
    start_reset();
    src_on = 4'b1111;
    set_len(2);
    end_reset();
    wait_grants("rr_wait", 8);
    for (int i = 0; i < 8; i++) chk("rr_order", glog[gbase+i], exp_rr[i]);
    chk("rr_latch", latch_cnt - lbase, 7);
    chk("rr_viol", viol - vbase, 0);

    // weights {3,1,2,1}, then weight[0]=0 mid-round
    start_reset();
    wgt = 16'h1213;
    end_reset();
    wait_grants("w_wait1", 9);
    wgt = 16'h1210;
    wait_grants("w_wait2", 21);
    for (int i = 0; i < 21; i++) chk("w_order", glog[gbase+i], exp_w[i]);
    chk("w_viol", viol - vbase, 0);

    // single-beat frames on ports 1 and 3
    start_reset();
    wgt = 16'h1111;
    src_on = 4'b1010;
    set_len(1);
    end_reset();
    wait_grants("sb_wait", 4);
    for (int i = 0; i < 4; i++) chk("sb_order", glog[gbase+i], exp_sb[i]);
    chk("sb_period", gstamp[gbase+1] - gstamp[gbase], 3);
    chk("sb_period2", gstamp[gbase+3] - gstamp[gbase+2], 3);
    chk("sb_latch", latch_cnt - lbase, 3);
    chk("sb_frames", frames[1] + frames[3] - fbase[1] - fbase[3], 3);
    chk("sb_viol", viol - vbase, 0);

    // mask port 1 mid-frame
    start_reset();
    src_on = 4'b0011;
    set_len(4);
    end_reset();
    wait_grants("mk_wait1", 2);
    pen = 4'b1101;
    wait_grants("mk_wait2", 5);
    chk("mk_frames1", frames[1] - fbase[1], 1);
    pen = 4'b1111;
    wait_grants("mk_wait3", 6);
    for (int i = 0; i < 6; i++) chk("mk_order", glog[gbase+i], exp_mk[i]);
    chk("mk_viol", viol - vbase, 0);
    chk("no_early_stall", stall_cnt, 0);

    // watchdog, then reset mid-frame
    start_reset();
    src_on = 4'b0011;
    end_reset();
    found = 0;
    for (int k = 0; k < 50 && found == 0; k++) begin
      @(negedge clk);
      #1;
      if (mhs) found = 1;
    end
    chk("wd_first_hs", found, 1);
    @(posedge clk);
    #1;
    sink_ready = 1'b0;
    pulses  = 0;
    pulse_n = -1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      #1;
      if (stall) begin
        pulses++;
        pulse_n = n;
      end
    end
    chk("wd_pulses", pulses, 1);
    chk("wd_pulse_at", pulse_n, 9);
    chk("wd_busy", int'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_enable", int'(enable), 0);
    chk("mid_rst_select", int'(select), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    sink_ready = 1'b1;
    end_reset();
    wait_grants("post_rst_wait", 1);
    chk("post_rst_grant", glog[gbase], 0);
    chk("stall_total", stall_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
